seq_stream_ctrl: RTL and testbench

Controller for the one-hot four-in-a-row sequence detector (input w, synchronous active-low reset, output z = four equal consecutive bits). Two requesters each present a WIDTH-bit word. The block arbitrates between them, clears the detector, and serializes the granted word MSB-first onto the detector's w input, one bit per clock. It counts z pulses over the word and returns the match count with a done pulse. It sits between requester logic and the detector instance, on the detector's clock.

---
 rtl/seq_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_seq_stream_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// Arbitrates two requesters and serializes the granted word MSB-first into the
// four-in-a-row detector, then reports the z count. Define SEQ_CTRL_FIXED_PRI_EN for fixed priority.
module seq_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             det_w,
  output logic             det_clr,
  input  logic             det_z,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sel;
  logic             pick;

`ifdef SEQ_CTRL_FIXED_PRI_EN
  always_comb begin
    pick = ~req[0];
  end
`else
  logic ptr;

  always_comb begin
    pick = (req == 2'b11) ? ptr : req[1];
  end
`endif

  // Saturating count of the current det_z sample.
  always_comb begin
    cnt_inc = cnt;
    if (det_z && (cnt != '1)) begin
      cnt_inc = cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      cnt       <= '0;
      sel       <= 1'b0;
      gnt       <= '0;
      det_w     <= 1'b0;
      det_clr   <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      match_cnt <= '0;
`ifndef SEQ_CTRL_FIXED_PRI_EN
      ptr       <= 1'b0;
`endif
    end else begin
      gnt     <= '0;
      det_w   <= 1'b0;
      det_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            sreg    <= pick ? data1 : data0;
            sel     <= pick;
            gnt     <= pick ? 2'b10 : 2'b01;
            det_clr <= 1'b1;
            state   <= CLEAR;
`ifndef SEQ_CTRL_FIXED_PRI_EN
            ptr     <= ~pick;
`endif
          end
        end
        CLEAR: begin
          // Outputs are registered, so the first serial bit is staged here.
          cnt   <= '0;
          idx   <= '0;
          det_w <= sreg[WIDTH-1];
          sreg  <= {sreg[WIDTH-2:0], 1'b0};
          state <= SHIFT;
        end
        SHIFT: begin
          if (idx != '0) begin
            cnt <= cnt_inc;
          end
          if (idx == IDX_W'(WIDTH - 1)) begin
            state <= DRAIN;
          end else begin
            det_w <= sreg[WIDTH-1];
            sreg  <= {sreg[WIDTH-2:0], 1'b0};
            idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          // Last z sample folds straight into the reported count.
          done      <= 1'b1;
          done_id   <= sel;
          match_cnt <= cnt_inc;
          state     <= REPORT;
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl with a behavioural four-in-a-row detector
// and a word-level reference model for arbitration and match counting.
module tb_seq_stream_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [W-1:0]  data0 = '0;
  logic [W-1:0]  data1 = '0;
  logic [1:0]    gnt;
  logic          det_w;
  logic          det_clr;
  logic          det_z;
  logic          done;
  logic          done_id;
  logic [CW-1:0] match_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  seq_stream_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .det_w(det_w), .det_clr(det_clr), .det_z(det_z),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Detector: z is high once the last four applied bits are equal; sync clear.
  int unsigned run = 0;
  logic        lastb = 1'b0;
  always @(posedge clk) begin
    if (det_clr) run <= 0;
    else if (run == 0 || det_w != lastb) begin
      run   <= 1;
      lastb <= det_w;
    end else if (run < 4) run <= run + 1;
  end
  assign det_z = (run == 4);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_count(input logic [W-1:0] d);
    int unsigned n = 0;
    logic [3:0] w4;
    for (int i = 3; i < W; i++) begin
      w4 = {d[W+2-i], d[W+1-i], d[W-i], d[W-1-i]};
      if (w4 == 4'h0 || w4 == 4'hF) n++;
    end
    return (n > (2**CW - 1)) ? (2**CW - 1) : n;
  endfunction

  typedef struct {
    bit           id;
    logic [W-1:0] data;
    int unsigned  cnt;
    bit           gap;
  } item_t;

  item_t exp_q[$];

  // Monitor
  bit           infl = 0;
  bit           have_last = 0;
  item_t        cur;
  int unsigned  gcyc = 0;
  int unsigned  last_g = 0;
  logic [W-1:0] bits = '0;

  always @(negedge clk) begin
    int unsigned k;
    if (rst) begin
      infl      = 0;
      have_last = 0;
    end else begin
      k = cyc - gcyc;
      if (infl) begin
        if (k >= 1 && k <= W) bits = {bits[W-2:0], det_w};
        if (k == W + 1) check("drain_det_w", det_w, 0);
        if (k == W + 2) begin
          check("done", done, 1);
          check("done_id", done_id, cur.id);
          check("match_cnt", match_cnt, cur.cnt);
          check("serial_word", bits, cur.data);
          infl = 0;
        end else if (done) check("early_done", done, 0);
      end else if (done) check("unexpected_done", done, 0);

      if (gnt != 0) begin
        if (exp_q.size() == 0) check("unexpected_gnt", gnt, 0);
        else begin
          cur = exp_q.pop_front();
          check("gnt", gnt, cur.id ? 2'b10 : 2'b01);
          check("det_clr_on_gnt", det_clr, 1);
          if (cur.gap && have_last) check("gnt_spacing", cyc - last_g, W + 4);
          last_g    = cyc;
          have_last = 1;
          gcyc      = cyc;
          infl      = 1;
          bits      = '0;
        end
      end else if (det_clr) check("stray_det_clr", det_clr, 0);
    end
  end

  // Stimulus and reference arbitration
  bit [1:0]     pending = '0;
  logic [W-1:0] pd[2];
  bit           mptr = 0;
  bit           gap_flag = 0;
  bit           fresh = 0;

  task automatic raise(input int i, input logic [W-1:0] d);
    pd[i] = d;
    if (i == 0) data0 = d;
    else data1 = d;
    req[i]     = 1'b1;
    pending[i] = 1'b1;
  endtask

  task automatic serve_one();
    bit    win;
    bit    seen = 0;
    item_t it;
`ifdef SEQ_CTRL_FIXED_PRI_EN
    win = pending[0] ? 1'b0 : 1'b1;
`else
    win = (pending == 2'b11) ? mptr : pending[1];
`endif
    it.id   = win;
    it.data = pd[win];
    it.cnt  = ref_count(pd[win]);
    it.gap  = gap_flag;
    exp_q.push_back(it);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (gnt != 0) seen = 1;
    end
    if (!seen) begin
      check("grant_timeout", 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    req[win]     = 1'b0;
    pending[win] = 1'b0;
    mptr         = ~win;
    fresh        = 1;
    gap_flag     = (pending != 0);
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
    fresh    = 0;
    gap_flag = 0;
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_det_w", det_w, 0);
    check("rst_det_clr", det_clr, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_match_cnt", match_cnt, 0);
    rst = 1'b0;
    idle_cycles(3);

    // Directed words
    raise(0, 8'h00); serve_one(); idle_cycles(15);
    raise(0, 8'hF0); serve_one(); idle_cycles(15);
    raise(1, 8'hAA); serve_one(); idle_cycles(15);
    raise(0, 8'h00); raise(1, 8'hFF); serve_one();
    raise(0, 8'h00); gap_flag = 1; serve_one();
    raise(1, 8'hFF); gap_flag = 1; serve_one();

    // Random traffic
    repeat (40) begin
      if (pending == 0 && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(14, 20));
      else gap_flag = fresh;
      for (int i = 0; i < 2; i++)
        if (!pending[i] && $urandom_range(0, 1) == 1) raise(i, rand_word());
      if (pending == 0) raise(int'($urandom_range(0, 1)), rand_word());
      serve_one();
    end
    while (pending != 0) serve_one();
    idle_cycles(15);

    // Abort a transfer with reset during the fourth SHIFT cycle
    raise(0, 8'h00); serve_one(); idle_cycles(15);
    raise(0, 8'hFF); serve_one();
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_det_w", det_w, 1);
    rst     = 1'b1;
    req     = '0;
    pending = '0;
    mptr    = 0;
    #1;
    check("abort_det_w", det_w, 0);
    check("abort_gnt", gnt, 0);
    check("abort_done", done, 0);
    check("abort_match_cnt", match_cnt, 0);
    check("abort_det_clr", det_clr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(20);

    // Pointer must favour requester 0 again, then a lone req[1]
    raise(0, rand_word()); raise(1, rand_word()); serve_one(); serve_one();
    idle_cycles(15);
    raise(1, 8'hAA); serve_one();
    idle_cycles(15);
    check("queue_drained", exp_q.size(), 0);
    check("no_inflight", infl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
